b_writeback: RTL
================

B_WRITEBACK -- requirements
Module: b_writeback

Interface
REQ-001 The block SHALL have parameter LOG_Q, default 16, giving the modulus exponent; sums are reduced mod 2^LOG_Q per 16-bit lane, with 1 <= LOG_Q <= 16.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the result-word FIFO depth; it SHALL be a power of 2 and at least 2.
REQ-003 clk  in  1  sole clock; all state is updated on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-005 start  in  1  single-cycle job start pulse, honoured only in IDLE.
REQ-006 BASE_ADDR_E  in  32  byte base address of the error matrix E; sampled on an accepted start.
REQ-007 BASE_ADDR_B  in  32  byte base address of the output matrix B; sampled on an accepted start.
REQ-008 NUM_WORDS  in  11  number of 64-bit words in the job; sampled on an accepted start.
REQ-009 res_valid  in  1  a systolic result word is present on res_data.
REQ-010 res_data  in  64  four 16-bit lanes of A*S, lane 0 in bits [15:0].
REQ-011 res_ready  out  1  the block accepts res_data in this cycle.
REQ-012 rd_addr  out  32  BRAM read byte address for the E word.
REQ-013 rd_en  out  1  BRAM read strobe.
REQ-014 bram_data_e  in  64  BRAM read data, valid exactly 1 cycle after rd_en.
REQ-015 wr_addr  out  32  BRAM write byte address.
REQ-016 wen  out  1  BRAM write enable.
REQ-017 wdata  out  64  B word to be written.
REQ-018 busy  out  1  high whenever the state is not IDLE.
REQ-019 done  out  1  one-cycle pulse marking job completion.

Function
REQ-020 The block SHALL implement the states IDLE, RUN, DRAIN and FIN.
REQ-021 In IDLE, start SHALL latch the three configuration inputs, clear all counters and the FIFO, and move to RUN; when NUM_WORDS==0 it SHALL move to FIN instead.
REQ-022 res_ready SHALL equal (state==RUN) AND (FIFO not full) AND (accepted count < NUM_WORDS).
- A handshake occurs when res_valid and res_ready are both high.
- Each handshake pushes res_data into the FIFO and increments the accepted count.
REQ-023 The state SHALL move from RUN to DRAIN in the cycle after the accepted count reaches NUM_WORDS.
REQ-024 Whenever the FIFO is non-empty and the issue index is less than NUM_WORDS, the block SHALL perform an issue in that cycle:
- pop the FIFO head into the stage-1 register;
- drive rd_en=1 and rd_addr=BASE_ADDR_E+idx*8;
- increment idx.
REQ-025 One cycle after an issue, the block SHALL compute wdata[16k+15:16k] = (res_lane_k + e_lane_k) mod 2^LOG_Q for k=0..3, with bits at and above LOG_Q in each lane zeroed.
- That cycle SHALL register wen=1 and wr_addr=BASE_ADDR_B+idx_at_issue*8.
- wen, wr_addr and wdata SHALL therefore become visible 2 cycles after the issue.
REQ-026 Issue throughput SHALL be 1 word per cycle sustained, with no bubbles while the FIFO is non-empty.
REQ-027 A push and a pop in the same cycle SHALL leave the FIFO occupancy unchanged; a push SHALL occur only when the FIFO is not full, including in that same cycle.
REQ-028 All address arithmetic SHALL be 32-bit and wrap modulo 2^32.
REQ-029 In DRAIN, once all NUM_WORDS writes have been registered, the state SHALL move to FIN.
REQ-030 FIN SHALL last 1 cycle, in which done=1 is driven, and SHALL then return to IDLE.
- For NUM_WORDS=N>0 with res_valid held high, done SHALL fall exactly 3 cycles after the Nth handshake.
REQ-031 start while busy SHALL be ignored, and the latched configuration SHALL remain unchanged.
REQ-032 res_valid while res_ready=0 SHALL have no effect; upstream holds the data until a handshake occurs.
REQ-033 rd_en and wen SHALL be 0 in every cycle in which no issue or write occurs.
- wdata and wr_addr SHALL hold their last values when wen=0.

Reset
REQ-034 While rst_n=0, the block SHALL be in IDLE with the FIFO empty and all counters 0.
- The following outputs SHALL be 0: res_ready, rd_en, rd_addr, wen, wr_addr, wdata, busy and done.
REQ-035 Assertion of reset mid-job SHALL abort the job immediately, with no further writes after the asynchronous clear.
- After release, the block SHALL accept a new start in the first clock cycle.

Verification
REQ-036 Basic job: NUM_WORDS=4, BASE_E=0x100, BASE_B=0x200, res_valid held high, res lanes=0x0001, E lanes=0x0002 -> four writes to 0x200/0x208/0x210/0x218 with wdata=0x0003000300030003, then a single done pulse.
REQ-037 Modular wrap: LOG_Q=15, res lane=0x7FFF, E lane=0x0003 -> that wdata lane=0x0002; LOG_Q=16, res lane=0xFFFF, E lane=0x0001 -> that lane=0x0000.
REQ-038 Backpressure: FIFO_DEPTH=4, NUM_WORDS=8, res_valid toggling every cycle -> exactly 8 writes in order, no gaps in wr_addr, and res_ready never high while the FIFO is full.
REQ-039 Empty job: NUM_WORDS=0 -> busy high for exactly 1 cycle (FIN), done pulses in that cycle, and rd_en and wen stay 0.
REQ-040 Start ignored and reset abort: start pulsed mid-job -> configuration unchanged; rst_n dropped after 2 writes -> all outputs 0 at once, and a fresh 2-word job afterwards completes correctly.

Source files
------------

// File: rtl/b_writeback.sv
// b_writeback: adds buffered systolic result words to E words fetched from BRAM,
// reduces each 16-bit lane mod 2^LOG_Q and writes the resulting B words back.
`timescale 1ns/1ps

module b_writeback #(
    parameter int unsigned LOG_Q      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] BASE_ADDR_E,
    input  logic [31:0] BASE_ADDR_B,
    input  logic [10:0] NUM_WORDS,
    input  logic        res_valid,
    input  logic [63:0] res_data,
    output logic        res_ready,
    output logic [31:0] rd_addr,
    output logic        rd_en,
    input  logic [63:0] bram_data_e,
    output logic [31:0] wr_addr,
    output logic        wen,
    output logic [63:0] wdata,
    output logic        busy,
    output logic        done
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned LANES  = DATA_W / LANE_W;
    localparam int unsigned CNT_W  = 11;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W  = PTR_W + 1;

    // Keeps lane bits below LOG_Q; LOG_Q=16 yields all ones.
    localparam logic [LANE_W-1:0] LANE_MASK = LANE_W'((32'd1 << LOG_Q) - 32'd1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    // Control state
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_busy;
    logic              r_done;

    // Latched job configuration
    logic [ADDR_W-1:0] r_base_e;
    logic [ADDR_W-1:0] r_base_b;
    logic [CNT_W-1:0]  r_num;

    // Progress counters
    logic [CNT_W-1:0]  r_acc_cnt;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [CNT_W-1:0]  w_wr_cnt_nxt;

    // Result-word FIFO
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [OCC_W-1:0]  r_occ;
    logic              w_full;
    logic              w_empty;

    // Stage 1: popped result word waiting for its E word
    logic              r_s1_vld;
    logic [DATA_W-1:0] r_s1_data;
    logic [CNT_W-1:0]  r_s1_idx;

    // Write stage
    logic              r_wen;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_start_ok;
    logic              w_push;
    logic              w_issue;
    logic [DATA_W-1:0] w_sum;

    assign w_start_ok   = (r_state == S_IDLE) && start;
    assign w_full       = (r_occ == OCC_W'(FIFO_DEPTH));
    assign w_empty      = (r_occ == '0);
    assign res_ready    = (r_state == S_RUN) && !w_full && (r_acc_cnt < r_num);
    assign w_push       = res_valid && res_ready;
    assign w_issue      = !w_empty && (r_idx < r_num);
    assign w_wr_cnt_nxt = r_wr_cnt + CNT_W'(r_s1_vld);

    assign rd_en   = w_issue;
    assign rd_addr = r_base_e + ADDR_W'({r_idx, 3'b000});
    assign wen     = r_wen;
    assign wr_addr = r_wr_addr;
    assign wdata   = r_wdata;
    assign busy    = r_busy;
    assign done    = r_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DRAIN exits on the edge that registers the last write
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (NUM_WORDS == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (r_acc_cnt == r_num) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_wr_cnt_nxt == r_num) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered status outputs track the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_FIN);
        end
    end

    // Configuration latch, counters, FIFO pointers and stage-1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base_e  <= '0;
            r_base_b  <= '0;
            r_num     <= '0;
            r_acc_cnt <= '0;
            r_idx     <= '0;
            r_wr_cnt  <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_occ     <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
            r_s1_idx  <= '0;
        end else if (w_start_ok) begin
            r_base_e  <= BASE_ADDR_E;
            r_base_b  <= BASE_ADDR_B;
            r_num     <= NUM_WORDS;
            r_acc_cnt <= '0;
            r_idx     <= '0;
            r_wr_cnt  <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_occ     <= '0;
            r_s1_vld  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr    <= r_wptr + PTR_W'(1);
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            end
            if (w_issue) begin
                r_rptr    <= r_rptr + PTR_W'(1);
                r_idx     <= r_idx + CNT_W'(1);
                r_s1_data <= r_mem[r_rptr];
                r_s1_idx  <= r_idx;
            end
            case ({w_push, w_issue})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
            r_s1_vld <= w_issue;
            r_wr_cnt <= w_wr_cnt_nxt;
        end
    end

    // FIFO storage; contents need no reset since occupancy guards every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= res_data;
        end
    end

    // Per-lane modular add of result and E word
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            w_sum[k*LANE_W +: LANE_W] =
                (r_s1_data[k*LANE_W +: LANE_W] + bram_data_e[k*LANE_W +: LANE_W]) & LANE_MASK;
        end
    end

    // Write stage; address and data hold between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen     <= 1'b0;
            r_wr_addr <= '0;
            r_wdata   <= '0;
        end else begin
            r_wen <= r_s1_vld;
            if (r_s1_vld) begin
                r_wdata   <= w_sum;
                r_wr_addr <= r_base_b + ADDR_W'({r_s1_idx, 3'b000});
            end
        end
    end

endmodule
